// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comm_pkg
// Brief    : Shared types and helpers for the UART framing blocks.
// Revision : 1.0 - initial release
// ============================================================================
package comm_pkg;

   localparam int BYTE_W = 8;

   // Fill side: EMPTY while no byte of the current word has arrived.
   typedef enum logic {
      EMPTY   = 1'b0,
      FILLING = 1'b1
   } fill_state_t;

   // Output side: HELD while word_out carries an unaccepted word.
   typedef enum logic {
      FREE = 1'b0,
      HELD = 1'b1
   } out_state_t;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : idle_timer
// Brief    : Counts enabled clocks since the last clear and emits a one-cycle
//            expired pulse after TIMEOUT_CYCLES of them. The count restarts
//            from zero when it expires, so a persistent enable gives a
//            periodic pulse.
// Revision : 1.0 - initial release
// ============================================================================
module idle_timer
   import comm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int                CNT_W    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;
   logic             expired_q;

   // Idle counter; clear has priority so any activity restarts the interval.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         expired_q <= 1'b0;
      end else begin
         expired_q <= 1'b0;
         if (clear) begin
            count <= '0;
         end else if (enable) begin
            if (count == CNT_LAST) begin
               count     <= '0;
               expired_q <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

   assign expired = expired_q;

endmodule
`default_nettype wire

// File: rtl/uart_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_assembler
// Brief    : Packs UART receive bytes LSB-first into words, presents them on a
//            valid/ready port with a per-message last flag, drops completed
//            words that find the output still occupied (sticky overflow), and
//            discards partial words after an inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_assembler
   import comm_pkg::*;
#(
   parameter int BYTES_PER_WORD    = 4,
   parameter int WORDS_PER_MESSAGE = 64,
   parameter int TIMEOUT_CYCLES    = 1_000_000
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             byte_valid_in,
   input  logic [BYTE_W-1:0]                byte_in,
   output logic                             word_valid_out,
   input  logic                             word_ready_in,
   output logic [BYTE_W*BYTES_PER_WORD-1:0] word_out,
   output logic                             word_last_out,
   output logic                             timeout_out,
   output logic                             overflow_out
);

   localparam int                WORD_W    = BYTE_W * BYTES_PER_WORD;
   localparam int                IDX_W     = cnt_width(BYTES_PER_WORD);
   localparam int                WCNT_W    = cnt_width(WORDS_PER_MESSAGE);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_MESSAGE - 1);

   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_eff;
   logic [IDX_W-1:0]  idx_next;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_eff;
   logic [WCNT_W-1:0] wcnt_next;
   logic [WORD_W-1:0] fill;
   logic [WORD_W-1:0] fill_next;
   logic [WORD_W-1:0] word_q;
   logic              last_q;
   logic              overflow_q;
   fill_state_t       fill_state;
   out_state_t        out_state;
   out_state_t        out_state_next;
   logic              expired;
   logic              complete;
   logic              load;
   logic              drop;

   assign fill_state = (idx == '0) ? EMPTY : FILLING;

   // Timer runs only while a partial word is pending; it is held off during
   // its own expiry pulse so the discard does not start a second interval.
   idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk     (clk_in),
      .rst     (rst_in),
      .clear   (byte_valid_in),
      .enable  ((fill_state == FILLING) && !expired),
      .expired (expired)
   );

   // Byte placement and word completion; an expiry this cycle makes the
   // current byte (if any) the first byte of a fresh word and message.
   always_comb begin
      idx_eff   = expired ? '0 : idx;
      wcnt_eff  = expired ? '0 : wcnt;
      fill_next = fill;
      if (byte_valid_in) begin
         fill_next[idx_eff*BYTE_W +: BYTE_W] = byte_in;
      end
      complete = byte_valid_in && (idx_eff == IDX_LAST);
      // A held word accepted this cycle frees the slot for the new word.
      load     = complete && ((out_state == FREE) || word_ready_in);
      drop     = complete && !load;
      if (!byte_valid_in) begin
         idx_next = idx_eff;
      end else if (complete) begin
         idx_next = '0;
      end else begin
         idx_next = idx_eff + 1'b1;
      end
      if (load) begin
         wcnt_next = (wcnt_eff == WCNT_LAST) ? '0 : wcnt_eff + 1'b1;
      end else begin
         wcnt_next = wcnt_eff;
      end
   end

   // Output slot next-state: occupied on load, released by an accept.
   always_comb begin
      out_state_next = out_state;
      case (out_state)
         FREE:    if (load) out_state_next = HELD;
         HELD:    if (word_ready_in && !load) out_state_next = FREE;
         default: out_state_next = FREE;
      endcase
   end

   // Output slot state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         out_state <= FREE;
      end else begin
         out_state <= out_state_next;
      end
   end

   // Fill-side registers: byte index, message position and partial word.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         idx  <= '0;
         wcnt <= '0;
         fill <= '0;
      end else begin
         idx  <= idx_next;
         wcnt <= wcnt_next;
         fill <= fill_next;
      end
   end

   // Output word and last flag change only on load, so they stay stable
   // while held; overflow latches any dropped word until reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         word_q     <= '0;
         last_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (load) begin
            word_q <= fill_next;
            last_q <= (wcnt_eff == WCNT_LAST);
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign word_valid_out = (out_state == HELD);
   assign word_out       = word_q;
   assign word_last_out  = last_q;
   assign timeout_out    = expired;
   assign overflow_out   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_assembler
// Brief    : Directed scenarios plus randomized traffic for
//            uart_word_assembler, checked every cycle against a queue-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_assembler;

   localparam int BPW  = 4;
   localparam int WPM  = 2;
   localparam int TMO  = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        bv;
   logic [7:0]  b;
   logic        rdy;
   logic        wv;
   logic [31:0] w;
   logic        wl;
   logic        tmo;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   // Reference model state
   byte unsigned part[$];
   int           msg_pos;
   int           idle;
   logic         m_valid;
   logic         m_last;
   logic         m_tmo;
   logic         m_ovf;
   logic [31:0]  m_word;

   always #5 clk = ~clk;

   uart_word_assembler #(
      .BYTES_PER_WORD    (BPW),
      .WORDS_PER_MESSAGE (WPM),
      .TIMEOUT_CYCLES    (TMO)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .byte_valid_in  (bv),
      .byte_in        (b),
      .word_valid_out (wv),
      .word_ready_in  (rdy),
      .word_out       (w),
      .word_last_out  (wl),
      .timeout_out    (tmo),
      .overflow_out   (ovf)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      part.delete();
      msg_pos = 0;
      idle    = 0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_tmo   = 1'b0;
      m_ovf   = 1'b0;
      m_word  = '0;
   endtask

   // One clock of the reference model, using the inputs present at the edge.
   task automatic model_step();
      bit          pulse;
      bit          hs;
      bit          nxt_tmo;
      bit          loaded;
      logic [31:0] wd;
      pulse   = m_tmo;
      hs      = m_valid && rdy;
      nxt_tmo = 1'b0;
      loaded  = 1'b0;
      if (pulse) begin
         part.delete();
         msg_pos = 0;
      end
      if (bv) begin
         part.push_back(b);
         idle = 0;
         if (part.size() == BPW) begin
            wd = '0;
            for (int i = 0; i < BPW; i++) wd = wd | (32'(part[i]) << (8 * i));
            if (!m_valid || rdy) begin
               m_word  = wd;
               m_last  = (msg_pos == WPM - 1);
               msg_pos = (msg_pos + 1) % WPM;
               loaded  = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
            part.delete();
         end
      end else if (!pulse && part.size() > 0) begin
         idle++;
         if (idle == TMO) begin
            nxt_tmo = 1'b1;
            idle    = 0;
         end
      end
      if (loaded) m_valid = 1'b1;
      else if (hs) m_valid = 1'b0;
      m_tmo = nxt_tmo;
   endtask

   // Drive one cycle of inputs, advance model, compare outputs after the edge.
   task automatic tick(input bit v, input logic [7:0] d, input bit r);
      bv  = v;
      b   = d;
      rdy = r;
      @(posedge clk);
      model_step();
      #1;
      check_val("valid", wv, m_valid);
      check_val("timeout", tmo, m_tmo);
      check_val("overflow", ovf, m_ovf);
      if (m_valid) begin
         check_val("word", w, m_word);
         check_val("last", wl, m_last);
      end
   endtask

   task automatic send_word(input logic [31:0] data, input bit r);
      for (int i = 0; i < BPW; i++) tick(1'b1, data[8*i +: 8], r);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_valid"}, wv, 0);
      check_val({tag, "_word"}, w, 0);
      check_val({tag, "_last"}, wl, 0);
      check_val({tag, "_timeout"}, tmo, 0);
      check_val({tag, "_overflow"}, ovf, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int first_pulse;
      int gap;
      logic [31:0] held;

      rst = 1'b1;
      bv  = 1'b0;
      b   = '0;
      rdy = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Basic packing, ready high
      send_word(32'h44332211, 1'b1);
      check_val("s1_valid", wv, 1);
      check_val("s1_word", w, 32'h44332211);
      check_val("s1_last", wl, 0);
      tick(1'b0, 8'h00, 1'b1);
      check_val("s1_drained", wv, 0);

      // Back-to-back words: last flag on the second message word, then wrap
      send_word(32'h08070605, 1'b1);
      check_val("s2_last1", wl, 1);
      send_word(32'h0C0B0A09, 1'b1);
      check_val("s2_wrap_last", wl, 0);
      check_val("s2_wrap_word", w, 32'h0C0B0A09);
      tick(1'b0, 8'h00, 1'b1);

      // Ready low: first held stable, second dropped, overflow sticky
      send_word(32'hBBBBBB01, 1'b0);
      held = w;
      send_word(32'hCCCCCC02, 1'b0);
      check_val("s3_held", w, held);
      check_val("s3_held_val", w, 32'hBBBBBB01);
      check_val("s3_ovf", ovf, 1);
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b0, 8'h00, 1'b1);
      check_val("s3_drained", wv, 0);
      check_val("s3_ovf_sticky", ovf, 1);

      // Advance message position so the timeout's reset of it is observable
      send_word(32'h04030201, 1'b1);
      tick(1'b0, 8'h00, 1'b1);

      // Timeout: two bytes then idle
      tick(1'b1, 8'h55, 1'b1);
      tick(1'b1, 8'h66, 1'b1);
      pulses      = 0;
      first_pulse = -1;
      for (int i = 1; i <= 150; i++) begin
         tick(1'b0, 8'h00, 1'b1);
         if (tmo) begin
            pulses++;
            if (first_pulse < 0) first_pulse = i;
         end
      end
      check_val("s4_pulses", pulses, 1);
      check_val("s4_pulse_cycle", first_pulse, TMO);
      send_word(32'hA4A3A2A1, 1'b1);
      check_val("s4_word", w, 32'hA4A3A2A1);
      check_val("s4_last", wl, 0);
      tick(1'b0, 8'h00, 1'b1);

      // Reset mid-word with a held word and sticky overflow
      send_word(32'h13121110, 1'b0);
      tick(1'b1, 8'h21, 1'b0);
      tick(1'b1, 8'h22, 1'b0);
      tick(1'b1, 8'h23, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      model_reset();
      bv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send_word(32'hD4D3D2D1, 1'b1);
      check_val("s6_word", w, 32'hD4D3D2D1);
      check_val("s6_last", wl, 0);
      tick(1'b0, 8'h00, 1'b1);

      // Completion coinciding with handshake of the held word
      send_word(32'hC4C3C2C1, 1'b0);
      tick(1'b1, 8'hE1, 1'b0);
      tick(1'b1, 8'hE2, 1'b0);
      tick(1'b1, 8'hE3, 1'b0);
      tick(1'b1, 8'hE4, 1'b1);
      check_val("s5_valid", wv, 1);
      check_val("s5_word", w, 32'hE4E3E2E1);
      check_val("s5_ovf", ovf, 0);
      tick(1'b0, 8'h00, 1'b1);

      // Randomized traffic with occasional long gaps
      gap = 0;
      for (int i = 0; i < 3000; i++) begin
         if (gap > 0) begin
            gap--;
            tick(1'b0, 8'h00, ($urandom_range(0, 9) < 7));
         end else begin
            tick(($urandom_range(0, 9) < 5), 8'($urandom), ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 49) == 0) gap = $urandom_range(90, 120);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_word_assembler.md
# uart_word_assembler

Consumes the byte stream produced by the laptop-facing UART receiver (`new_data_out` / `data_byte_out`) and packs consecutive bytes, LSB-first, into fixed-width words for the downstream ciphertext datapath. Words are presented on a valid/ready interface and tagged with a last-word flag once per message. An inter-byte timeout discards partial words so a dropped byte cannot permanently misalign framing.

## Interface
Parameters:
- `BYTES_PER_WORD`, default 4: bytes per output word; output width is 8*BYTES_PER_WORD.
- `WORDS_PER_MESSAGE`, default 64: words per message; sets the `word_last_out` position.
- `TIMEOUT_CYCLES`, default 1_000_000: idle clocks after which a partial word is discarded (10 ms at 100 MHz, about 10 byte-times at 9600 baud).

Ports:
- `clk_in`  in  1  system clock (100 MHz).
- `rst_in`  in  1  reset, asynchronous, active-high.
- `byte_valid_in`  in  1  one-cycle strobe; `byte_in` is valid.
- `byte_in`  in  8  received byte.
- `word_valid_out`  out  1  `word_out` holds a complete word.
- `word_ready_in`  in  1  downstream accepts the word.
- `word_out`  out  8*BYTES_PER_WORD  assembled word.
- `word_last_out`  out  1  word is the final word of a message; qualified by `word_valid_out`.
- `timeout_out`  out  1  one-cycle pulse: a partial word was discarded.
- `overflow_out`  out  1  sticky: a completed word was dropped; cleared only by reset.

## Operation
- Fill register (8*BYTES_PER_WORD bits), byte index `idx` (0..BYTES_PER_WORD-1), output register, message word counter `wcnt` (0..WORDS_PER_MESSAGE-1).
- Fill states:
  - EMPTY (`idx`=0): waits for a byte.
  - FILLING (`idx`>0): accumulating bytes.
- Output register states:
  - FREE
  - HELD (`word_valid_out`=1)
- Each `byte_valid_in` writes `byte_in` to bits [8*idx+7 : 8*idx], then `idx` increments.
- When the byte arrives at `idx`=BYTES_PER_WORD-1, the word completes and `idx` returns to 0 (EMPTY). On completion:
  - If the output register is FREE, or is released by a handshake in the same cycle, the word loads into it. `word_last_out` is set to (`wcnt`==WORDS_PER_MESSAGE-1), and `wcnt` increments, wrapping to 0 after the last word.
  - Otherwise the word is dropped: `overflow_out` sets, `wcnt` is unchanged, and the held word is untouched.
- Handshake: transfer occurs when `word_valid_out` && `word_ready_in`. Output data and `word_last_out` stay stable while HELD.
- Timeout: an idle counter clears on every byte and counts only in FILLING. On reaching TIMEOUT_CYCLES:
  - `idx` and `wcnt` return to 0.
  - `timeout_out` pulses for one cycle.
  - The held output word is retained.
- A byte arriving in the same cycle the timeout fires is processed as the first byte of a new word (`idx`=0 → 1). `timeout_out` still pulses.
- Bytes in EMPTY never trigger a timeout.

## Timing
- Reset values: `word_valid_out`=0, `word_out`=0, `word_last_out`=0, `timeout_out`=0, `overflow_out`=0, `idx`=0, `wcnt`=0, idle counter 0.
- Latency: final byte strobe in cycle t gives `word_valid_out`=1 in cycle t+1.
- After a handshake in cycle t, `word_valid_out`=0 in t+1 unless a new word completed in t.
- `word_ready_in` may be high before valid. No combinational path from `word_ready_in` to any output.
- Timeout pulse is asserted in the cycle after the idle counter reaches TIMEOUT_CYCLES-1.
- Reset mid-word or mid-hold abandons all state immediately (asynchronous). The first byte after deassertion is byte 0.

## Structure
- Shared package `comm_pkg`:
  - `localparam BYTE_W = 8`
  - typedef for fill state `{EMPTY, FILLING}`
  - typedef for output state `{FREE, HELD}`
- One sub-module, `idle_timer`: a parameterised cycle counter with inputs clear and enable, and a one-cycle `expired` pulse. It is reusable by other UART framing blocks.
- Counter widths use `$clog2` of the respective parameters.

## Test plan
Parameters for all scenarios: BYTES_PER_WORD=4, WORDS_PER_MESSAGE=2, TIMEOUT_CYCLES=100.
- Bytes 0x11, 0x22, 0x33, 0x44 with ready high → `word_out`=0x44332211 with `word_valid_out` one cycle after the 4th strobe; `word_last_out`=0.
- Two words back-to-back → second word has `word_last_out`=1; a third word has `word_last_out`=0 (wrap).
- Ready low while two words arrive → first word held stable; second dropped; `overflow_out`=1 sticky. Releasing ready yields only the first word.
- Two bytes, then 100 idle cycles → `timeout_out` pulses once. The next four bytes 0xA1..0xA4 give 0xA4A3A2A1 with `word_last_out`=0.
- Word completes in the same cycle as a handshake of the held word → no overflow; new word valid the next cycle.
- `rst_in` asserted after 3 bytes → all outputs zero immediately; the next four bytes form a fresh word.
